// File: rtl/csa_pkg.sv
// Parameter derivation and legality helpers for the pipelined carry-select adder.
package csa_pkg;

  // Number of BLK-bit carry-select slices in a WIDTH-bit operand.
  function automatic int unsigned csa_nblk(input int unsigned width, input int unsigned blk);
    return (blk == 0) ? 0 : width / blk;
  endfunction

  // Number of pipeline stages when SEG slices are resolved per stage.
  function automatic int unsigned csa_stages(input int unsigned width, input int unsigned blk,
                                             input int unsigned seg);
    return (seg == 0) ? 0 : csa_nblk(width, blk) / seg;
  endfunction

  // True when the WIDTH/BLK/SEG combination tiles evenly into whole stages.
  function automatic bit csa_params_ok(input int unsigned width, input int unsigned blk,
                                       input int unsigned seg);
    if (width == 0 || blk == 0 || seg == 0) return 1'b0;
    if ((width % blk) != 0) return 1'b0;
    if ((csa_nblk(width, blk) % seg) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/csa_block.sv
// One BLK-bit carry-select slice: both carry-in outcomes are precomputed,
// the real carry only steers the output mux.
module csa_block #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK-1:0] s0;
  logic [BLK-1:0] s1;
  logic [BLK:0]   c0;
  logic [BLK:0]   c1;

  // Two ripple adders, one assuming carry-in 0 and one assuming carry-in 1.
  always_comb begin
    s0    = '0;
    s1    = '0;
    c0    = '0;
    c1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < int'(BLK); i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign s  = ci ? s1 : s0;
  assign co = ci ? c1[BLK] : c0[BLK];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder: sum = (a + b + cin) mod 2^WIDTH, cout = true carry.
// Each stage resolves SEG slices of BLK bits using the carry registered by the
// previous stage; unconsumed operand bits ride along in forwarding registers.
// Valid/ready handshake on both sides; bubbles collapse while the output stalls.
// Optional macro CSA_OVF_EN adds the signed-overflow output ovf.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = 4,
  parameter int unsigned SEG   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBLK   = csa_nblk(WIDTH, BLK);
  localparam int unsigned STAGES = NBLK / SEG;
  localparam int unsigned SW     = BLK * SEG;
  localparam int unsigned LAST   = STAGES - 1;

  // Reject parameter sets that do not tile into whole slices and stages.
  if (!csa_params_ok(WIDTH, BLK, SEG)) begin : g_bad_params
    $error("csa_pipe_adder: illegal WIDTH/BLK/SEG combination");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] ld;
  logic [STAGES:0]   rdy;

  // Ready chain from the output back to the input, and per-stage load enables.
  always_comb begin
    rdy         = '0;
    v_in        = '0;
    v_d         = v_q;
    rdy[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
    v_in[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      v_in[k] = v_q[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      if (rdy[k]) v_d[k] = v_in[k];
    end
    // Datapath only captures real data, so a stage holds its contents through bubbles.
    ld = rdy[STAGES-1:0] & v_in;
  end

  // Per-stage valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stg
    localparam int unsigned LO  = s * SW;
    localparam int unsigned REM = WIDTH - LO;

    logic [REM-1:0]     op_a;
    logic [REM-1:0]     op_b;
    logic               op_c;
    wire  [SEG:0]       cc;
    logic [SW-1:0]      slc;
    logic [LO+SW-1:0]   res_d;
    logic [LO+SW-1:0]   res_q;
    logic               c_q;

    // Stage inputs: the primary operands for stage 0, forwarded bits otherwise.
    if (s == 0) begin : g_src
      assign op_a  = a;
      assign op_b  = b;
      assign op_c  = cin;
      assign res_d = slc;
    end else begin : g_src
      assign op_a  = g_stg[s-1].g_fwd.fa_q;
      assign op_b  = g_stg[s-1].g_fwd.fb_q;
      assign op_c  = g_stg[s-1].c_q;
      assign res_d = {slc, g_stg[s-1].res_q};
    end

    assign cc[0] = op_c;

    // Carry ripples slice to slice through the select muxes only.
    for (genvar j = 0; j < int'(SEG); j++) begin : g_slc
      csa_block #(.BLK(BLK)) u_blk (
        .a  (op_a[j*BLK +: BLK]),
        .b  (op_b[j*BLK +: BLK]),
        .ci (cc[j]),
        .s  (slc[j*BLK +: BLK]),
        .co (cc[j+1])
      );
    end

    // Resolved sum bits and the carry out of this stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
        c_q   <= 1'b0;
      end else if (ld[s]) begin
        res_q <= res_d;
        c_q   <= cc[SEG];
      end
    end

    // Operand bits still to be resolved by later stages.
    if (REM > SW) begin : g_fwd
      logic [REM-SW-1:0] fa_q;
      logic [REM-SW-1:0] fb_q;

      // Forward the unconsumed upper operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fa_q <= '0;
          fb_q <= '0;
        end else if (ld[s]) begin
          fa_q <= op_a[REM-1:SW];
          fb_q <= op_b[REM-1:SW];
        end
      end
    end

`ifdef CSA_OVF_EN
    logic [1:0] sg_in;

    if (s == 0) begin : g_sg_src
      assign sg_in = {a[WIDTH-1], b[WIDTH-1]};
    end else begin : g_sg_src
      assign sg_in = g_stg[s-1].g_sg.sg_q;
    end

    if (s < int'(LAST)) begin : g_sg
      logic [1:0] sg_q;

      // Carry the operand sign bits down to the stage that produces the sum MSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sg_q <= 2'b00;
        else if (ld[s])  sg_q <= sg_in;
      end
    end else begin : g_sg
      logic ovf_q;

      // Signed overflow: like-signed operands whose sum flips sign.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ovf_q <= 1'b0;
        else if (ld[s]) ovf_q <= (sg_in[1] == sg_in[0]) & (slc[SW-1] != sg_in[1]);
      end
    end
`endif
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[LAST];
  assign sum       = g_stg[LAST].res_q;
  assign cout      = g_stg[LAST].c_q;
`ifdef CSA_OVF_EN
  assign ovf       = g_stg[LAST].g_sg.ovf_q;
`endif

endmodule
